spi_sram_responder: RTL

SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

---
 rtl/spi_sram_pkg.sv | 19 +
 rtl/spi_sram_byte_mem.sv | 25 ++
 rtl/spi_sram_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_pkg.sv
// Shared constants for the SQI SPI SRAM link: opcodes, FSM states, nibble count.
package spi_sram_pkg;

  localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
  localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;

  localparam int NIBBLES_PER_BYTE = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    WRITE,
    READ,
    IGNORE
  } sram_state_e;

endpackage

// File: rtl/spi_sram_byte_mem.sv
// Byte storage: one write port, one synchronous read port with 1-clk latency.
// Contents are deliberately not reset.
module spi_sram_byte_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] rd_data_q;

  // Array write and registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/spi_sram_responder.sv
// SQI-mode SPI SRAM responder (23LC1024 READ/WRITE subset).
// Optional macro SPI_SRAM_RESP_DUMMY_EN inserts a one-byte dummy phase before
// read data; it must match the build of the spi_sram_encoder on the other end.
//
// state  | meaning
// IDLE   | waiting for a chip-select falling edge
// CMD    | collecting the two opcode nibbles
// ADDR   | collecting SPI_ADDR_BITS/4 address nibbles, low bits kept
// DUMMY  | one dummy byte before read data (macro builds only)
// WRITE  | assembling bytes from rising-edge nibbles and committing them
// READ   | driving nibbles on falling edges, address advancing per byte
// IGNORE | unsupported opcode, idle until chip select rises
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int SPI_ADDR_BITS  = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sram_cs_n,
  input  logic sram_sck,
  input  logic sram_sio0_i,
  input  logic sram_sio1_i,
  input  logic sram_sio2_i,
  input  logic sram_sio3_i,
  output logic sram_sio0_o,
  output logic sram_sio1_o,
  output logic sram_sio2_o,
  output logic sram_sio3_o,
  output logic sram_sio_oe,
  output logic cmd_error
);

  localparam int         AW        = MEM_ADDR_WIDTH;
  localparam logic [7:0] ADDR_LAST = 8'(SPI_ADDR_BITS / 4 - 1);
  localparam logic [7:0] NIB_LAST  = 8'(NIBBLES_PER_BYTE - 1);

  sram_state_e   state_q, state_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    hold_q, hold_d;
  logic          is_read_q, is_read_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    sio_o_q, sio_o_d;
  logic          oe_q, oe_d;
  logic          err_q, err_d;

  logic          sck_rise, sck_fall, cs_fall;
  logic [3:0]    nib_in;
  logic [7:0]    opcode;
  logic          mem_we;
  logic [7:0]    mem_rdata;

  assign nib_in   = {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};
  assign sck_rise = sram_sck & ~sck_q;
  assign sck_fall = ~sram_sck & sck_q;
  assign cs_fall  = cs_n_q & ~sram_cs_n;
  assign opcode   = {hold_q, nib_in};

  // The read port always follows the current address, so the next byte is
  // already fetched by the time its first nibble is due.
  spi_sram_byte_mem #(.ADDR_WIDTH(AW)) u_mem (
    .clk    (clk),
    .wr_en  (mem_we),
    .wr_addr(addr_q),
    .wr_data(opcode),
    .rd_addr(addr_q),
    .rd_data(mem_rdata)
  );

  // Next-state, datapath and output computation; chip select high overrides all.
  always_comb begin
    state_d   = state_q;
    sck_d     = sram_sck;
    cs_n_d    = sram_cs_n;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    sio_o_d   = sio_o_q;
    oe_d      = oe_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;

    if (sram_cs_n) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      cnt_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          oe_d = 1'b0;
          if (cs_fall) begin
            state_d = CMD;
            cnt_d   = NIB_LAST;
          end
        end
        CMD: begin
          if (sck_rise) begin
            if (cnt_q != 8'd0) begin
              hold_d = nib_in;
              cnt_d  = cnt_q - 8'd1;
            end else if (opcode == SRAM_CMD_WRITE || opcode == SRAM_CMD_READ) begin
              is_read_d = (opcode == SRAM_CMD_READ);
              state_d   = ADDR;
              cnt_d     = ADDR_LAST;
            end else begin
              state_d = IGNORE;
              err_d   = 1'b1;
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_d = AW'({addr_q, nib_in});
            if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
            end else begin
              cnt_d = NIB_LAST;
              if (!is_read_q) begin
                state_d = WRITE;
              end else begin
`ifdef SPI_SRAM_RESP_DUMMY_EN
                state_d = DUMMY;
`else
                state_d = READ;
`endif
              end
            end
          end
        end
`ifdef SPI_SRAM_RESP_DUMMY_EN
        DUMMY: begin
          if (sck_rise) begin
            if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
            end else begin
              state_d = READ;
              cnt_d   = NIB_LAST;
            end
          end
        end
`endif
        WRITE: begin
          if (sck_rise) begin
            if (cnt_q != 8'd0) begin
              hold_d = nib_in;
              cnt_d  = cnt_q - 8'd1;
            end else begin
              mem_we = 1'b1;
              addr_d = addr_q + AW'(1);
              cnt_d  = NIB_LAST;
            end
          end
        end
        READ: begin
          if (sck_fall) begin
            oe_d = 1'b1;
            if (cnt_q != 8'd0) begin
              sio_o_d = mem_rdata[7:4];
              cnt_d   = cnt_q - 8'd1;
            end else begin
              sio_o_d = mem_rdata[3:0];
              addr_d  = addr_q + AW'(1);
              cnt_d   = NIB_LAST;
            end
          end
        end
        IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset. The chip
  // select copy resets low so a select held through reset is not a new edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      sio_o_q   <= '0;
      oe_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      sio_o_q   <= sio_o_d;
      oe_q      <= oe_d;
      err_q     <= err_d;
    end
  end

  assign sram_sio3_o = sio_o_q[3];
  assign sram_sio2_o = sio_o_q[2];
  assign sram_sio1_o = sio_o_q[1];
  assign sram_sio0_o = sio_o_q[0];
  assign sram_sio_oe = oe_q;
  assign cmd_error   = err_q;

endmodule
